// File: rtl/write_back_unit.sv
// Write-back stage: registers MEM-stage results into the register-file strobes and
// stalls upstream while a load or pop waits for data memory, aborting after TIMEOUT waits.
module write_back_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        writeBackEnMEM,
  input  logic        memReadMEM,
  input  logic        pushEnMEM,
  input  logic        popEnMEM,
  input  logic [3:0]  destMEM,
  input  logic [31:0] aluResultMEM,
  input  logic        memReady,
  input  logic [31:0] memData,
  output logic [3:0]  destWB,
  output logic [31:0] resultWB,
  output logic        writeBackEnWB,
  output logic        pushEnWB,
  output logic        popEnWB,
  output logic        freeze,
  output logic        memError
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic wb;
    logic push;
    logic pop;
  } strobes_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       hold_dest_q, hold_dest_d;
  strobes_t         hold_stb_q, hold_stb_d;
  logic [3:0]       dest_q, dest_d;
  logic [31:0]      result_q, result_d;
  strobes_t         stb_q, stb_d;
  logic             err_q, err_d;
  logic             freeze_c;

  strobes_t in_stb;
  logic     read_op, any_op;

  assign in_stb  = '{wb: writeBackEnMEM, push: pushEnMEM, pop: popEnMEM};
  assign read_op = memReadMEM | popEnMEM;
  assign any_op  = read_op | writeBackEnMEM | pushEnMEM;

  // Next-state, write-back payload and stall decision
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_dest_d = hold_dest_q;
    hold_stb_d  = hold_stb_q;
    dest_d      = dest_q;
    result_d    = result_q;
    stb_d       = '0;
    err_d       = err_q;
    freeze_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (read_op) begin
          if (memReady) begin
            dest_d   = destMEM;
            result_d = memData;
            stb_d    = in_stb;
          end else begin
            hold_dest_d = destMEM;
            hold_stb_d  = in_stb;
            cnt_d       = '0;
            state_d     = S_WAIT;
            freeze_c    = 1'b1;
          end
        end else if (any_op) begin
          dest_d   = destMEM;
          result_d = aluResultMEM;
          stb_d    = in_stb;
        end
      end
      S_WAIT: begin
        // MEM-stage inputs are frozen upstream, so only memory handshake matters here
        if (memReady) begin
          dest_d   = hold_dest_q;
          result_d = memData;
          stb_d    = hold_stb_q;
          state_d  = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          freeze_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_dest_q <= '0;
      hold_stb_q  <= '0;
      dest_q      <= '0;
      result_q    <= '0;
      stb_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_dest_q <= hold_dest_d;
      hold_stb_q  <= hold_stb_d;
      dest_q      <= dest_d;
      result_q    <= result_d;
      stb_q       <= stb_d;
      err_q       <= err_d;
    end
  end

  assign freeze        = freeze_c & ~rst;
  assign destWB        = dest_q;
  assign resultWB      = result_q;
  assign writeBackEnWB = stb_q.wb;
  assign pushEnWB      = stb_q.push;
  assign popEnWB       = stb_q.pop;
  assign memError      = err_q;

endmodule

// File: tb/tb_write_back_unit.sv
// Bench for write_back_unit: transaction-level model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_write_back_unit;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        writeBackEnMEM, memReadMEM, pushEnMEM, popEnMEM;
  logic [3:0]  destMEM;
  logic [31:0] aluResultMEM;
  logic        memReady;
  logic [31:0] memData;
  logic [3:0]  destWB;
  logic [31:0] resultWB;
  logic        writeBackEnWB, pushEnWB, popEnWB, freeze, memError;

  int n_vec = 0;
  int n_err = 0;

  write_back_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .writeBackEnMEM(writeBackEnMEM),
    .memReadMEM    (memReadMEM),
    .pushEnMEM     (pushEnMEM),
    .popEnMEM      (popEnMEM),
    .destMEM       (destMEM),
    .aluResultMEM  (aluResultMEM),
    .memReady      (memReady),
    .memData       (memData),
    .destWB        (destWB),
    .resultWB      (resultWB),
    .writeBackEnWB (writeBackEnWB),
    .pushEnWB      (pushEnWB),
    .popEnWB       (popEnWB),
    .freeze        (freeze),
    .memError      (memError)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pending read is a transaction with an age; outputs are what the rules say
  bit          armed = 1'b0;
  bit          m_pend = 1'b0;
  int unsigned m_age = 0;
  logic [3:0]  m_hdest;
  logic [2:0]  m_hstb;
  logic [3:0]  e_dest;
  logic [31:0] e_res;
  logic [2:0]  e_stb;
  logic        e_err;

  always @(posedge clk) begin
    armed = 1'b1;
    if (rst) begin
      m_pend = 1'b0; m_age = 0; e_dest = '0; e_res = '0; e_stb = '0; e_err = 1'b0;
    end else begin
      e_stb = '0;
      if (m_pend) begin
        if (memReady) begin
          e_dest = m_hdest; e_res = memData; e_stb = m_hstb; m_pend = 1'b0;
        end else if (m_age + 1 == TIMEOUT) begin
          e_err = 1'b1; m_pend = 1'b0;
        end else begin
          m_age++;
        end
      end else if (memReadMEM || popEnMEM) begin
        if (memReady) begin
          e_dest = destMEM; e_res = memData;
          e_stb = {writeBackEnMEM, pushEnMEM, popEnMEM};
        end else begin
          m_pend = 1'b1; m_age = 0; m_hdest = destMEM;
          m_hstb = {writeBackEnMEM, pushEnMEM, popEnMEM};
        end
      end else if (writeBackEnMEM || pushEnMEM) begin
        e_dest = destMEM; e_res = aluResultMEM;
        e_stb = {writeBackEnMEM, pushEnMEM, popEnMEM};
      end
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    logic e_frz;
    if (armed) begin
      e_frz = 1'b0;
      if (!rst) begin
        if (!m_pend) e_frz = (memReadMEM || popEnMEM) && !memReady;
        else         e_frz = !memReady && (m_age + 1 < TIMEOUT);
      end
      cmp("m_freeze", 32'(freeze), 32'(e_frz));
      cmp("m_destWB", 32'(destWB), 32'(e_dest));
      cmp("m_resultWB", resultWB, e_res);
      cmp("m_strobes", 32'({writeBackEnWB, pushEnWB, popEnWB}), 32'(e_stb));
      cmp("m_memError", 32'(memError), 32'(e_err));
    end
  end

  task automatic idle_in();
    writeBackEnMEM = 0; memReadMEM = 0; pushEnMEM = 0; popEnMEM = 0;
    destMEM = '0; aluResultMEM = '0; memReady = 0; memData = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int frz_cnt;
    rst = 1'b1;
    idle_in();
    memReadMEM = 1;
    tick(); tick();
    #1;
    cmp("rst_freeze", 32'(freeze), 32'd0);
    cmp("rst_destWB", 32'(destWB), 32'd0);
    cmp("rst_resultWB", resultWB, 32'd0);
    cmp("rst_strobes", 32'({writeBackEnWB, pushEnWB, popEnWB}), 32'd0);
    cmp("rst_memError", 32'(memError), 32'd0);

    // Direct op right after reset falls
    rst = 1'b0; idle_in();
    writeBackEnMEM = 1; destMEM = 4'd3; aluResultMEM = 32'h10;
    #1 cmp("dir_freeze", 32'(freeze), 32'd0);
    tick();
    cmp("dir_wb", 32'(writeBackEnWB), 32'd1);
    cmp("dir_dest", 32'(destWB), 32'd3);
    cmp("dir_res", resultWB, 32'h10);

    // Zero-wait load
    idle_in();
    memReadMEM = 1; writeBackEnMEM = 1; destMEM = 4'd5; aluResultMEM = 32'h99;
    memReady = 1; memData = 32'hCAFE;
    #1 cmp("zw_freeze", 32'(freeze), 32'd0);
    tick();
    cmp("zw_res", resultWB, 32'hCAFE);
    cmp("zw_dest", 32'(destWB), 32'd5);
    cmp("zw_wb", 32'(writeBackEnWB), 32'd1);

    // No op: strobes drop, payload holds
    idle_in();
    tick();
    cmp("idle_wb", 32'(writeBackEnWB), 32'd0);
    cmp("idle_hold", resultWB, 32'hCAFE);

    // Three-wait load with junk on MEM inputs during the wait
    idle_in();
    memReadMEM = 1; writeBackEnMEM = 1; destMEM = 4'd7; aluResultMEM = 32'h55;
    frz_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        idle_in();
        pushEnMEM = 1; destMEM = 4'd9; aluResultMEM = 32'hDEAD;
      end
      memReady = (i == 3); memData = (i == 3) ? 32'h1234 : 32'hFFFF;
      #1 if (freeze) frz_cnt++;
      tick();
      if (i < 3) cmp("w3_nostrobe", 32'({writeBackEnWB, pushEnWB, popEnWB}), 32'd0);
    end
    cmp("w3_freeze_cycles", 32'(frz_cnt), 32'd3);
    cmp("w3_strobes", 32'({writeBackEnWB, pushEnWB, popEnWB}), 32'b100);
    cmp("w3_dest", 32'(destWB), 32'd7);
    cmp("w3_res", resultWB, 32'h1234);
    idle_in();
    tick();
    cmp("w3_single_pulse", 32'(writeBackEnWB), 32'd0);

    // Timeout on a pop
    idle_in();
    popEnMEM = 1; writeBackEnMEM = 1; destMEM = 4'd2;
    frz_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) idle_in();
      #1 if (freeze) frz_cnt++;
      tick();
      cmp("to_nostrobe", 32'({writeBackEnWB, pushEnWB, popEnWB}), 32'd0);
      if (i < 4) cmp("to_err_early", 32'(memError), 32'd0);
    end
    cmp("to_freeze_cycles", 32'(frz_cnt), 32'd4);
    cmp("to_err", 32'(memError), 32'd1);

    // Ops continue after an error, flag is sticky
    idle_in();
    writeBackEnMEM = 1; destMEM = 4'd4; aluResultMEM = 32'h44;
    tick();
    cmp("post_err_wb", 32'(writeBackEnWB), 32'd1);
    cmp("post_err_res", resultWB, 32'h44);
    cmp("post_err_sticky", 32'(memError), 32'd1);

    // Reset in the middle of a wait
    idle_in();
    memReadMEM = 1; writeBackEnMEM = 1; destMEM = 4'd6;
    tick();
    idle_in();
    tick();
    rst = 1'b1;
    #1 cmp("rw_freeze_rst", 32'(freeze), 32'd0);
    tick();
    rst = 1'b0; memReady = 1; memData = 32'hBEEF;
    #1 cmp("rw_freeze", 32'(freeze), 32'd0);
    tick();
    cmp("rw_nostrobe", 32'({writeBackEnWB, pushEnWB, popEnWB}), 32'd0);
    cmp("rw_err", 32'(memError), 32'd0);
    cmp("rw_res", resultWB, 32'd0);

    // Back-to-back push, zero-wait pop, direct op
    idle_in();
    pushEnMEM = 1; destMEM = 4'd13; aluResultMEM = 32'h100;
    tick();
    cmp("b2b_push_stb", 32'({writeBackEnWB, pushEnWB, popEnWB}), 32'b010);
    cmp("b2b_push_res", resultWB, 32'h100);
    idle_in();
    popEnMEM = 1; writeBackEnMEM = 1; destMEM = 4'd8; memReady = 1; memData = 32'h200;
    tick();
    cmp("b2b_pop_stb", 32'({writeBackEnWB, pushEnWB, popEnWB}), 32'b101);
    cmp("b2b_pop_res", resultWB, 32'h200);
    cmp("b2b_pop_dest", 32'(destWB), 32'd8);
    idle_in();
    writeBackEnMEM = 1; destMEM = 4'd1; aluResultMEM = 32'h300;
    tick();
    cmp("b2b_dir_stb", 32'({writeBackEnWB, pushEnWB, popEnWB}), 32'b100);
    cmp("b2b_dir_res", resultWB, 32'h300);

    // Several strobes together pass through
    idle_in();
    writeBackEnMEM = 1; pushEnMEM = 1; destMEM = 4'd10; aluResultMEM = 32'hABC;
    tick();
    cmp("multi_stb", 32'({writeBackEnWB, pushEnWB, popEnWB}), 32'b110);
    cmp("multi_res", resultWB, 32'hABC);

    idle_in();
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/write_back_unit.md
WRITE_BACK_UNIT -- requirements
Module: write_back_unit

Interface
REQ-001 Parameter: TIMEOUT, default 255; the number of WAIT cycles after which a pending memory read is aborted (range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: writeBackEnMEM  input  1  MEM-stage instruction writes a register.
REQ-005 Port: memReadMEM  input  1  MEM-stage instruction is a load.
REQ-006 Port: pushEnMEM / popEnMEM  input  1 each  MEM-stage instruction is a stack push / pop.
REQ-007 Port: destMEM  input  4  destination register index.
REQ-008 Port: aluResultMEM  input  32  ALU result or address.
REQ-009 Port: memReady  input  1  data memory has valid read data this cycle.
REQ-010 Port: memData  input  32  data memory read data; qualified by memReady.
REQ-011 Port: destWB  output  4  register-file write index.
REQ-012 Port: resultWB  output  32  register-file write data.
REQ-013 Port: writeBackEnWB / pushEnWB / popEnWB  output  1 each  register-file write and stack-pointer update strobes.
REQ-014 Port: freeze  output  1  stall request to the fetch, decode and MEM stages.
REQ-015 Port: memError  output  1  sticky flag: a read timed out.

Function
REQ-016 A data-read op SHALL be defined as memReadMEM or popEnMEM high; any other op with at least one strobe high is a direct op.
REQ-017 The FSM SHALL have exactly two states, IDLE and WAIT; reset SHALL enter IDLE.
REQ-018 IDLE, direct op: the next edge SHALL register destMEM, aluResultMEM and the strobes into the WB outputs (latency 1); state SHALL stay IDLE.
REQ-019 IDLE, data-read op with memReady=1: the next edge SHALL register resultWB=memData, destWB=destMEM and the strobes; state SHALL stay IDLE (latency 1, no freeze).
REQ-020 IDLE, data-read op with memReady=0: the edge SHALL latch destMEM and the strobes into holding registers, clear the counter, enter WAIT, and drive all WB strobes to 0.
REQ-021 WAIT: MEM-stage inputs SHALL be ignored, because upstream is held by freeze.
REQ-022 WAIT with memReady=1: the edge SHALL output the held dest and strobes with resultWB=memData, then return to IDLE.
REQ-023 WAIT with memReady=0: the counter SHALL increment by 1 (8-bit, no wrap).
REQ-024 WAIT with memReady=0 and counter==TIMEOUT-1: the edge SHALL abort, with WB strobes 0, memError set to 1, and state IDLE.
REQ-025 freeze SHALL be combinational: (IDLE and data-read op and memReady=0) or (WAIT and memReady=0 and counter<TIMEOUT-1).
REQ-026 freeze SHALL be 0 on the cycle when memReady=1 completes a read, and on the abort cycle.
REQ-027 WB strobes SHALL be single-cycle pulses per op; with no op in IDLE, all strobes SHALL be 0 on the next cycle.
REQ-028 destWB and resultWB SHALL hold their last value whenever all strobes are 0.
REQ-029 A push SHALL be a direct op: resultWB=aluResultMEM and pushEnWB=1; popEnWB SHALL be 0.
REQ-030 When several strobes are high together, they SHALL pass through unchanged; the block SHALL NOT arbitrate between them.
REQ-031 memError SHALL stay 1 until reset; later ops SHALL proceed normally.

Reset
REQ-032 Reset SHALL force: state IDLE, counter 0, all WB strobes 0, destWB 0, resultWB 0, memError 0.
REQ-033 The freeze output SHALL be 0 while rst is high.
REQ-034 Reset during WAIT SHALL discard the pending read; no write-back SHALL occur for it.
REQ-035 The first op SHALL be accepted on the first edge after rst falls.

Verification
REQ-036 Direct op: writeBackEnMEM=1, destMEM=3, aluResultMEM=0x10 -> next cycle writeBackEnWB=1, destWB=3, resultWB=0x10, freeze=0 throughout.
REQ-037 Zero-wait load: memReadMEM=1, writeBackEnMEM=1, destMEM=5, memReady=1, memData=0xCAFE -> next cycle resultWB=0xCAFE, destWB=5, no freeze.
REQ-038 Three-wait load: memReady=0 for 3 cycles then 1 with memData=0x1234 -> freeze high for exactly 3 cycles; one writeBackEnWB pulse with resultWB=0x1234; input changes during WAIT ignored.
REQ-039 Timeout with TIMEOUT=4: a pop with memReady held at 0 -> freeze high for 4 cycles, no WB strobe, then memError=1 and it stays 1.
REQ-040 Reset mid-WAIT: rst pulsed in cycle 2 of a wait, then memReady=1 -> no strobe, freeze=0, memError=0.
REQ-041 Back-to-back: a push, then a zero-wait pop, then a direct op on consecutive cycles -> three consecutive WB pulses in order with the correct strobes.
